// File: rtl/mips_int_pkg.sv
// mips_int_pkg: shared state encoding and sizing helpers for the interrupt controller.
package mips_int_pkg;
    typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;
    localparam logic [31:0] VECTOR_STRIDE = 32'd8;
    function automatic int id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/mips_irq_sync.sv
// mips_irq_sync: multi-flop synchroniser for one async interrupt line plus rising-edge detect.
module mips_irq_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic irq,
    output logic s,
    output logic rise
);
    logic [STAGES-1:0] sync;
    logic prev;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync <= '0;
            prev <= 1'b0;
        end else begin
            sync <= {sync[STAGES-2:0], irq};
            prev <= sync[STAGES-1];
        end
    end
    assign s    = sync[STAGES-1];
    assign rise = s & ~prev;
endmodule

// File: rtl/mips_int_ctrl.sv
// mips_int_ctrl: latches synchronised IRQ lines as pending requests and presents the
// lowest-index enabled one to the CPU with an ack / end-of-interrupt handshake.
module mips_int_ctrl
    import mips_int_pkg::*;
#(
    parameter int N_IRQ = 4,
    parameter int SYNC_STAGES = 2,
    parameter logic [31:0] VECTOR_BASE = 32'h0000_0180,
    parameter logic [N_IRQ-1:0] MASK_RESET = '1,
    localparam int ID_W = id_w(N_IRQ)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_IRQ-1:0] irq_in,
    input  logic [N_IRQ-1:0] edge_mode,
    input  logic             mask_we,
    input  logic [N_IRQ-1:0] mask_wdata,
    output logic             int_req,
    output logic [ID_W-1:0]  int_id,
    output logic [31:0]      int_vector,
    input  logic             int_ack,
    input  logic             int_eoi,
    output logic [N_IRQ-1:0] pending,
    output logic [N_IRQ-1:0] mask,
    output logic             in_service
);
    logic [N_IRQ-1:0] s, rise, clr, eligible;
    logic [ID_W-1:0] winner;
    state_t state;

    for (genvar g = 0; g < N_IRQ; g++) begin : g_line
        mips_irq_sync #(.STAGES(SYNC_STAGES)) u_sync (
            .clk (clk),
            .rst (rst),
            .irq (irq_in[g]),
            .s   (s[g]),
            .rise(rise[g])
        );
        assign clr[g] = (state == REQ) && int_ack && (int_id == ID_W'(g));
    end

    assign eligible = pending & mask;

    always_comb begin
        winner = '0;
        for (int i = N_IRQ - 1; i >= 0; i--)
            if (eligible[i]) winner = ID_W'(i);
    end

    // Edge lines hold until acked (a new rise wins over the clear); level lines track s.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending    <= '0;
            mask       <= MASK_RESET;
            state      <= IDLE;
            int_req    <= 1'b0;
            int_id     <= '0;
            in_service <= 1'b0;
        end else begin
            pending <= (edge_mode & (rise | (pending & ~clr))) | (~edge_mode & s);
            if (mask_we) mask <= mask_wdata;
            case (state)
                IDLE:
                    if (|eligible) begin
                        int_id  <= winner;
                        state   <= REQ;
                        int_req <= 1'b1;
                    end
                REQ:
                    if (int_ack) begin
                        state      <= SERVICE;
                        int_req    <= 1'b0;
                        in_service <= 1'b1;
                    end else if (!mask[int_id]) begin
                        state   <= IDLE;
                        int_req <= 1'b0;
                    end
                SERVICE:
                    if (int_eoi) begin
                        state      <= IDLE;
                        in_service <= 1'b0;
                    end
                default: state <= IDLE;
            endcase
        end
    end

    assign int_vector = VECTOR_BASE + 32'(int_id) * VECTOR_STRIDE;
endmodule

// File: tb/tb_mips_int_ctrl.sv
// tb_mips_int_ctrl: directed and random stimulus against a behavioural model; a monitor
// pops expected request ids from a scoreboard queue whenever int_req is newly raised.
module tb_mips_int_ctrl;
    import mips_int_pkg::*;
    localparam int N = 4;
    localparam int SS = 2;
    localparam int IW = id_w(N);
    localparam logic [31:0] VB = 32'h0000_0180;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [N-1:0] irq_in = '0, edge_mode = '1, mask_wdata = '0;
    logic mask_we = 1'b0, int_ack = 1'b0, int_eoi = 1'b0;
    logic int_req, in_service;
    logic [IW-1:0] int_id;
    logic [31:0] int_vector;
    logic [N-1:0] pending, mask;

    int checks = 0, errors = 0;

    // model: per-line sample history, pending bits, and handshake phase
    // (0 = nothing offered, 1 = offered and awaiting ack, 2 = handler running)
    bit hist[N][$];
    bit [N-1:0] m_pend, m_mask;
    int m_phase, m_id;
    int exp_q[$];
    logic last_req;

    mips_int_ctrl #(.N_IRQ(N), .SYNC_STAGES(SS), .VECTOR_BASE(VB)) dut (
        .clk(clk), .rst(rst), .irq_in(irq_in), .edge_mode(edge_mode),
        .mask_we(mask_we), .mask_wdata(mask_wdata), .int_req(int_req),
        .int_id(int_id), .int_vector(int_vector), .int_ack(int_ack),
        .int_eoi(int_eoi), .pending(pending), .mask(mask), .in_service(in_service)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            foreach (hist[i]) begin
                hist[i].delete();
                for (int k = 0; k < SS + 2; k++) hist[i].push_back(1'b0);
            end
            m_pend = '0;
            m_mask = '1;
            m_phase = 0;
            m_id = 0;
            exp_q.delete();
        end else begin
            bit [N-1:0] nxt;
            int first;
            first = -1;
            for (int i = N - 1; i >= 0; i--)
                if (m_pend[i] && m_mask[i]) first = i;
            for (int i = 0; i < N; i++) begin
                bit now_s, old_s, taken;
                hist[i].push_front(irq_in[i]);
                void'(hist[i].pop_back());
                now_s = hist[i][SS];
                old_s = hist[i][SS+1];
                taken = (m_phase == 1) && int_ack && (m_id == i);
                nxt[i] = edge_mode[i] ? ((now_s && !old_s) || (m_pend[i] && !taken)) : now_s;
            end
            if (m_phase == 0) begin
                if (first >= 0) begin
                    m_id = first;
                    m_phase = 1;
                    exp_q.push_back(first);
                end
            end else if (m_phase == 1) begin
                if (int_ack) m_phase = 2;
                else if (!m_mask[m_id]) m_phase = 0;
            end else if (int_eoi) m_phase = 0;
            m_pend = nxt;
            if (mask_we) m_mask = mask_wdata;
        end
    end

    always @(negedge clk) begin
        if (!rst) last_req = 1'b0;
        else begin
            chk("int_req", 32'(int_req), 32'(m_phase == 1));
            chk("in_service", 32'(in_service), 32'(m_phase == 2));
            chk("pending", 32'(pending), 32'(m_pend));
            chk("mask", 32'(mask), 32'(m_mask));
            if (int_req && !last_req) begin
                if (exp_q.size() == 0) chk("unexpected_req", 32'(int_id), 32'hFFFF_FFFF);
                else begin
                    int e;
                    e = exp_q.pop_front();
                    chk("sb_int_id", 32'(int_id), 32'(e));
                    chk("sb_int_vector", int_vector, 32'h180 + 32'(e) * 8);
                end
            end
            last_req = int_req;
        end
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_req(input string nm, input int exp_edges);
        int n = 0;
        while (!int_req && n < 20) begin
            step();
            n++;
        end
        chk(nm, 32'(n), 32'(exp_edges));
    endtask

    task automatic pulse_irq(input int i);
        irq_in[i] = 1'b1;
        step();
        irq_in[i] = 1'b0;
    endtask

    task automatic write_mask(input logic [N-1:0] v);
        mask_we = 1'b1;
        mask_wdata = v;
        step();
        mask_we = 1'b0;
    endtask

    task automatic serve();
        int_ack = 1'b1;
        step();
        int_ack = 1'b0;
        step();
        int_eoi = 1'b1;
        step();
        int_eoi = 1'b0;
    endtask

    task automatic chk_reset();
        chk("rst_int_req", 32'(int_req), 0);
        chk("rst_pending", 32'(pending), 0);
        chk("rst_mask", 32'(mask), 32'hF);
        chk("rst_in_service", 32'(in_service), 0);
        chk("rst_int_id", 32'(int_id), 0);
        chk("rst_int_vector", int_vector, 32'h180);
    endtask

    initial begin
        #3 rst = 1'b0;
        #1 chk_reset();
        step(2);
        rst = 1'b1;
        step();
        // single edge pulse on line 2
        pulse_irq(2);
        wait_req("lat_edge2", SS + 1);
        chk("t2_id", 32'(int_id), 2);
        chk("t2_vec", int_vector, 32'h190);
        int_ack = 1'b1;
        step();
        int_ack = 1'b0;
        chk("t2_pend_clr", 32'(pending[2]), 0);
        chk("t2_in_service", 32'(in_service), 1);
        int_eoi = 1'b1;
        step();
        int_eoi = 1'b0;
        chk("t2_eoi", 32'(in_service), 0);
        // simultaneous rises on lines 1 and 3
        irq_in = 4'b1010;
        step();
        irq_in = '0;
        wait_req("lat_pri", SS + 1);
        chk("t3_id_first", 32'(int_id), 1);
        serve();
        wait_req("t3_b2b", 1);
        chk("t3_id_second", 32'(int_id), 3);
        chk("t3_vec", int_vector, 32'h198);
        serve();
        step();
        // masking
        write_mask(4'b1110);
        pulse_irq(0);
        step(SS + 3);
        chk("t4_no_req", 32'(int_req), 0);
        chk("t4_pend0", 32'(pending[0]), 1);
        write_mask(4'hF);
        wait_req("t4_unmask", 1);
        chk("t4_id", 32'(int_id), 0);
        write_mask(4'h0);
        step();
        chk("t4_withdraw", 32'(int_req), 0);
        write_mask(4'hF);
        wait_req("t4_rereq", 1);
        serve();
        step(2);
        // level line 0
        edge_mode = 4'b1110;
        irq_in[0] = 1'b1;
        wait_req("lat_level", SS + 2);
        serve();
        wait_req("t5_level_rereq", 1);
        int_ack = 1'b1;
        step();
        int_ack = 1'b0;
        irq_in[0] = 1'b0;
        step(SS + 2);
        int_eoi = 1'b1;
        step();
        int_eoi = 1'b0;
        step(3);
        chk("t5_no_rereq", 32'(int_req), 0);
        edge_mode = 4'hF;
        // edge during service of the same line, spurious handshakes
        pulse_irq(2);
        wait_req("t6_req", SS + 1);
        int_eoi = 1'b1;
        step();
        int_eoi = 1'b0;
        chk("t6_eoi_in_req", 32'(int_req), 1);
        int_ack = 1'b1;
        step();
        int_ack = 1'b0;
        pulse_irq(2);
        int_ack = 1'b1;
        step();
        int_ack = 1'b0;
        step(SS + 1);
        chk("t6_pend_kept", 32'(pending[2]), 1);
        chk("t6_still_service", 32'(in_service), 1);
        int_eoi = 1'b1;
        step();
        int_eoi = 1'b0;
        wait_req("t6_rereq", 1);
        chk("t6_id", 32'(int_id), 2);
        serve();
        step();
        int_ack = 1'b1;
        step();
        int_ack = 1'b0;
        chk("t6_ack_idle", 32'(in_service), 0);
        // asynchronous reset mid-request
        pulse_irq(1);
        wait_req("t1_req", SS + 1);
        #2 rst = 1'b0;
        #1 chk_reset();
        edge_mode = N'($urandom);
        step(2);
        rst = 1'b1;
        // random traffic
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++)
                if ($urandom_range(0, 7) == 0) irq_in[i] = ~irq_in[i];
            int_ack = ($urandom_range(0, 3) == 0);
            int_eoi = ($urandom_range(0, 4) == 0);
            mask_we = ($urandom_range(0, 15) == 0);
            mask_wdata = N'($urandom);
            step();
        end
        {int_ack, int_eoi, mask_we} = '0;
        @(negedge clk);
        #1 chk("sb_drained", 32'(exp_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule

// File: doc/mips_int_ctrl.md
Name: mips_int_ctrl

Overview:
- Interrupt controller directly upstream of mips_cpu; drives the CPU's int0 input.
- Synchronises N asynchronous external interrupt lines and detects edges or levels per line.
- Latches pending requests, applies a software mask and selects one fixed-priority request.
- Presents that request to the CPU with an ack / end-of-interrupt handshake, plus the source id and handler vector.

Parameters:
- N_IRQ, 4, number of external interrupt lines (1..8).
- SYNC_STAGES, 2, flip-flop depth of each input synchroniser (>=2).
- VECTOR_BASE, 32'h0000_0180, handler address for source 0.
- MASK_RESET, all ones, reset value of the enable mask (1 = enabled).

Ports:
- clk  input  1  system clock.
- rst  input  1  reset; asynchronous, active-low.
- irq_in  input  N_IRQ  raw external interrupt lines, asynchronous to clk.
- edge_mode  input  N_IRQ  per line: 1 = rising-edge triggered, 0 = level triggered; static during operation.
- mask_we  input  1  mask write strobe.
- mask_wdata  input  N_IRQ  new mask value.
- int_req  output  1  request to CPU; connects to mips_cpu int0.
- int_id  output  $clog2(N_IRQ) (min 1)  selected source index.
- int_vector  output  32  VECTOR_BASE + (int_id << 3).
- int_ack  input  1  one-cycle pulse: CPU has taken the interrupt.
- int_eoi  input  1  one-cycle pulse: handler finished (eret).
- pending  output  N_IRQ  current pending bits, before masking.
- mask  output  N_IRQ  current mask register.
- in_service  output  1  high while a handler is in progress.

Behaviour:
- Reset (rst=0, asynchronous): all synchroniser flops 0, pending=0, mask=MASK_RESET, state=IDLE, int_req=0, int_id=0, in_service=0. int_vector=VECTOR_BASE.
- Synchroniser: SYNC_STAGES flops per line, producing s[i].
- Edge line: pending[i] is set on a rising edge of s[i] (s[i]=1 and previous s[i]=0). It is cleared only by int_ack for that line. Set takes priority over clear in the same cycle.
- Level line: pending[i] = s[i], registered. int_ack has no effect on it; the source must deassert.
- Mask: written on the clk edge where mask_we=1. The new value takes effect in the following cycle's arbitration.
- eligible = pending & mask. Priority: lowest index wins.
- State IDLE:
  - If eligible != 0: latch int_id = winner, go to REQ, and assert int_req from the next edge.
  - int_ack and int_eoi are ignored.
- State REQ:
  - int_req=1 and int_id are held stable.
  - int_ack=1: clear pending[int_id] (edge mode only), go to SERVICE, int_req=0 and in_service=1 from the next edge.
  - Else if mask[int_id]=0 (masked after selection): withdraw; go to IDLE with int_req=0.
  - A level source deasserting in REQ does NOT withdraw the request.
  - A higher-priority arrival does NOT replace the latched id.
  - int_eoi is ignored.
- State SERVICE:
  - No nesting; int_req stays 0.
  - int_eoi=1: go to IDLE, in_service=0.
  - int_ack is ignored.
  - New edges still set pending and are not lost.
- int_ack and int_eoi together in REQ: ack is taken, eoi is ignored.
- Latency from an irq_in rising edge (idle, enabled, SYNC_STAGES=2):
  - Edge 1 samples the line high.
  - pending[i] is set at edge 3.
  - int_req is high after edge 4. In general, int_req follows SYNC_STAGES+2 edges after sampling.
- Back-to-back service: after int_eoi, a still-eligible source re-requests at the second edge (IDLE, then REQ).
- All outputs are registered except int_vector, which is combinational from int_id.

Decomposition:
- Package mips_int_pkg:
  - state enum {IDLE, REQ, SERVICE};
  - ID_W function or constant;
  - VECTOR_STRIDE = 8.
- Sub-module mips_irq_sync: per-line synchroniser and rising-edge detector (outputs s and rise), instantiated N_IRQ times via generate.

Test Plan:
1. Reset: rst=0 mid-REQ -> int_req=0, pending=0, mask=4'hF, in_service=0, with no clk edge needed.
2. Edge line 2, mask=F, pulse irq_in[2] for 1 cycle -> int_req high 4 edges later, int_id=2, int_vector=32'h190; int_ack -> pending[2]=0, in_service=1; int_eoi -> IDLE.
3. Priority: lines 1 and 3 rise in the same cycle -> int_id=1 first. After ack/eoi -> int_req re-asserts 2 edges later with int_id=3, int_vector=32'h198.
4. Masking: mask=4'b1110, edge on line 0 -> no int_req and pending[0]=1. Write mask=F -> int_req 2 edges later with int_id=0. While in REQ, write mask=0 -> int_req drops and state is IDLE.
5. Level line 0 (edge_mode[0]=0), held high through ack/eoi -> re-request after eoi. Release before eoi -> no re-request.
6. Edge on line 2 while in SERVICE of line 2 -> pending[2]=1 is retained and re-requested after int_eoi. Spurious int_ack in IDLE and int_eoi in REQ have no effect.
